// File: rtl/seq_arb_pkg.sv
// rtl/seq_arb_pkg.sv - shared types and defaults for the arbitrated sequence detector
// State encoding, default pattern and requester IDs used by the top and the core.
package seq_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int DEF_W       = 8;
  localparam int DEF_PAT_LEN = 3;
  localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 3'b101;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

  // A lone requester always wins; on contention the favoured one (prio) wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic prio);
    case (req)
      2'b01:   return REQ_ID0;
      2'b10:   return REQ_ID1;
      default: return prio;
    endcase
  endfunction

endpackage

// File: rtl/seq_detect_core.sv
// rtl/seq_detect_core.sv - bit-serial overlapping pattern detector
// Y is combinational from history plus the current bit; CLR wins over EN.
module seq_detect_core
  import seq_arb_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
  input  logic CLK,
  input  logic RST,
  input  logic CLR,
  input  logic EN,
  input  logic X,
  output logic Y
);

  localparam int CNT_W = $clog2(PAT_LEN + 1);
  localparam logic [CNT_W-1:0] NEED = CNT_W'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(PAT_LEN);

  logic [PAT_LEN-1:0] hist;
  logic [PAT_LEN-1:0] cand;
  logic [CNT_W-1:0]   cnt;

  // cand is the most recent PAT_LEN bits including the one on X right now.
  assign cand = (hist << 1) | PAT_LEN'(X);
  assign Y    = EN && (cnt >= NEED) && (cand == PATTERN);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hist <= '0;
      cnt  <= '0;
    end else if (CLR) begin
      hist <= '0;
      cnt  <= '0;
    end else if (EN) begin
      hist <= cand;
      if (cnt != FULL) cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_arbiter.sv
// rtl/seq_detect_arbiter.sv - round-robin sharing of one serial detector between two word sources
// Grants a word, shifts it MSB-first through the detector, reports the hit count with the requester ID.
module seq_detect_arbiter
  import seq_arb_pkg::*;
#(
  parameter int                 W       = DEF_W,
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  parameter int                 CW      = $clog2(W + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [1:0]    REQ,
  input  logic [W-1:0]  DATA0,
  input  logic [W-1:0]  DATA1,
  output logic [1:0]    GNT,
  output logic          BUSY,
  output logic          X_OUT,
  output logic          Y_OUT,
  output logic          DONE,
  output logic          DONE_ID,
  output logic [CW-1:0] MATCH_CNT
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

  state_t        state, state_nxt;
  logic [W-1:0]  word;
  logic [IW-1:0] idx;
  logic [CW-1:0] hit_cnt;
  logic          owner;
  logic          prio;
  logic          winner;
  logic          start;
  logic          last_bit;
  logic          core_en;
  logic          core_clr;
  logic          core_y;

  assign winner = rr_pick(REQ, prio);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (REQ != 2'b00) state_nxt = SHIFT;
      SHIFT:   if (idx == '0)    state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start    = (state == IDLE) && (REQ != 2'b00);
    core_en  = (state == SHIFT);
    last_bit = core_en && (idx == '0);
    core_clr = start;
    BUSY     = (state != IDLE);
    X_OUT    = core_en ? word[idx] : 1'b0;
    Y_OUT    = core_y;
  end

  // The final hit is folded in at the last shift edge so MATCH_CNT is complete in REPORT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      word      <= '0;
      idx       <= '0;
      hit_cnt   <= '0;
      owner     <= REQ_ID0;
      prio      <= REQ_ID0;
      GNT       <= 2'b00;
      DONE      <= 1'b0;
      DONE_ID   <= 1'b0;
      MATCH_CNT <= '0;
    end else begin
      GNT  <= 2'b00;
      DONE <= 1'b0;
      if (start) begin
        word    <= winner ? DATA1 : DATA0;
        GNT     <= winner ? 2'b10 : 2'b01;
        idx     <= LAST_IDX;
        hit_cnt <= '0;
        owner   <= winner;
        prio    <= ~winner;
      end else if (core_en) begin
        idx     <= idx - IW'(1);
        hit_cnt <= hit_cnt + CW'(core_y);
        if (last_bit) begin
          DONE      <= 1'b1;
          DONE_ID   <= owner;
          MATCH_CNT <= hit_cnt + CW'(core_y);
        end
      end
    end
  end

  seq_detect_core #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN)
  ) u_core (
    .CLK (CLK),
    .RST (RST),
    .CLR (core_clr),
    .EN  (core_en),
    .X   (X_OUT),
    .Y   (core_y)
  );

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// tb/tb_seq_detect_arbiter.sv - self-checking bench for seq_detect_arbiter
// Vector table plus scoreboard of expected {DONE_ID, MATCH_CNT}, and hand sequences for corner cases.
module tb_seq_detect_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] REQ = 2'b00;
  logic [7:0] DATA0 = 8'h00;
  logic [7:0] DATA1 = 8'h00;
  logic [1:0] GNT;
  logic       BUSY, X_OUT, Y_OUT, DONE, DONE_ID;
  logic [3:0] MATCH_CNT;

  seq_detect_arbiter dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ       (REQ),
    .DATA0     (DATA0),
    .DATA1     (DATA1),
    .GNT       (GNT),
    .BUSY      (BUSY),
    .X_OUT     (X_OUT),
    .Y_OUT     (Y_OUT),
    .DONE      (DONE),
    .DONE_ID   (DONE_ID),
    .MATCH_CNT (MATCH_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       id;
    logic [3:0] cnt;
  } exp_t;

  typedef struct {
    logic [1:0] req;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_id;
    logic [3:0] exp_cnt;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST && DONE) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_id", DONE_ID, e.id);
        chk("match_cnt", MATCH_CNT, e.cnt);
      end
      done_seen++;
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int c = 0; c < 40; c++) begin
      if (!BUSY) begin
        ok = 1;
        break;
      end
      @(negedge CLK); #1;
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int target);
    bit got;
    got = 0;
    for (int c = 0; c < 30; c++) begin
      if (done_seen >= target) begin
        got = 1;
        break;
      end
      @(negedge CLK); #1;
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_word(input logic [1:0] req, input logic [7:0] d0, input logic [7:0] d1,
                          input logic eid, input logic [3:0] ecnt);
    int target;
    wait_idle();
    sb.push_back('{eid, ecnt});
    target = done_seen + 1;
    REQ = req; DATA0 = d0; DATA1 = d1;
    @(posedge CLK); #1;
    chk("gnt", GNT, eid ? 32'd2 : 32'd1);
    REQ = 2'b00;
    wait_done(target);
  endtask

  initial begin
    logic [7:0] w;
    logic [9:0] pw;
    int         done_at;
    int         target;
    int         ng;
    int         last_done;

    vecs[0] = '{2'b01, 8'hAA, 8'h00, 1'b0, 4'd3};
    vecs[1] = '{2'b10, 8'h00, 8'h05, 1'b1, 4'd1};
    vecs[2] = '{2'b10, 8'h00, 8'hFF, 1'b1, 4'd0};
    vecs[3] = '{2'b01, 8'h00, 8'h00, 1'b0, 4'd0};
    vecs[4] = '{2'b10, 8'h00, 8'h5A, 1'b1, 4'd2};
    vecs[5] = '{2'b01, 8'hA5, 8'h00, 1'b0, 4'd2};
    vecs[6] = '{2'b01, 8'h55, 8'h00, 1'b0, 4'd3};
    vecs[7] = '{2'b10, 8'h00, 8'hFD, 1'b1, 4'd1};

    // Reset state
    @(negedge CLK); @(negedge CLK); #1;
    chk("rst_gnt", GNT, 32'd0);
    chk("rst_busy", BUSY, 32'd0);
    chk("rst_done", DONE, 32'd0);
    chk("rst_done_id", DONE_ID, 32'd0);
    chk("rst_match_cnt", MATCH_CNT, 32'd0);
    chk("rst_x_out", X_OUT, 32'd0);
    chk("rst_y_out", Y_OUT, 32'd0);
    RST = 1'b0;

    // Single word from requester 0: bit stream, grant pulse width and DONE latency
    @(negedge CLK); #1;
    w = 8'hAA;
    pw = {2'b00, w};
    sb.push_back('{1'b0, 4'd3});
    target = done_seen + 1;
    REQ = 2'b01; DATA0 = w;
    @(posedge CLK);
    done_at = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK); #1;
      if (c == 1) begin
        chk("stream_gnt_on", GNT, 32'd1);
        REQ = 2'b00;
      end
      if (c == 2) chk("stream_gnt_off", GNT, 32'd0);
      if (c <= 8) begin
        chk("stream_x", X_OUT, w[8-c]);
        chk("stream_y", Y_OUT, (c >= 3) && (pw[(10-c) -: 3] == 3'b101));
        chk("stream_busy", BUSY, 32'd1);
      end
      if (DONE && done_at < 0) done_at = c;
    end
    chk("done_latency", done_at, 32'd9);
    wait_done(target);

    // Table of single-requester words
    for (int i = 0; i < 8; i++) begin
      run_word(vecs[i].req, vecs[i].d0, vecs[i].d1, vecs[i].exp_id, vecs[i].exp_cnt);
      @(negedge CLK); #1;
      chk("cnt_hold", MATCH_CNT, vecs[i].exp_cnt);
    end

    // Reset in the middle of a shift discards the word
    wait_idle();
    REQ = 2'b01; DATA0 = 8'hAA;
    @(posedge CLK);
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK);
      REQ = 2'b00;
    end
    RST = 1'b1;
    #1;
    chk("midrst_busy", BUSY, 32'd0);
    chk("midrst_gnt", GNT, 32'd0);
    chk("midrst_x", X_OUT, 32'd0);
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK); #1;
      chk("midrst_no_done", DONE, 32'd0);
    end
    run_word(2'b01, 8'hAA, 8'h00, 1'b0, 4'd3);

    // Both requesters held from reset: alternating grants, one IDLE cycle between words
    RST = 1'b1;
    REQ = 2'b11; DATA0 = 8'hAA; DATA1 = 8'h05;
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < 4; k++) sb.push_back((k % 2) ? '{1'b1, 4'd1} : '{1'b0, 4'd3});
    target = done_seen + 4;
    ng = 0;
    last_done = -100;
    for (int cyc = 0; cyc < 80 && done_seen < target; cyc++) begin
      @(negedge CLK); #1;
      if (DONE) last_done = cyc;
      if (GNT != 2'b00) begin
        chk("alt_gnt", GNT, (ng % 2) ? 32'd2 : 32'd1);
        if (ng > 0) chk("idle_gap", cyc - last_done, 32'd2);
        ng++;
        if (ng == 4) REQ = 2'b00;
      end
    end
    REQ = 2'b00;
    chk("alt_grant_count", ng, 32'd4);
    if (done_seen < target) chk("alt_done_timeout", 32'd0, 32'd1);

    // Requester 1 asserts only while busy and drops before IDLE: never granted
    wait_idle();
    sb.push_back('{1'b0, 4'd3});
    target = done_seen + 1;
    REQ = 2'b01; DATA0 = 8'h55; DATA1 = 8'hFF;
    @(posedge CLK); #1;
    chk("busy_req_gnt0", GNT, 32'd1);
    REQ = 2'b10;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK); #1;
      chk("busy_req_no_gnt1", GNT[1], 32'd0);
    end
    REQ = 2'b00;
    wait_done(target);
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK); #1;
      chk("busy_req_quiet", GNT, 32'd0);
    end
    run_word(2'b01, 8'hA5, 8'h00, 1'b0, 4'd2);

    @(negedge CLK); @(negedge CLK);
    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_detect_arbiter.md
Name: seq_detect_arbiter

Overview:
- Shares one serial pattern-detector datapath between two parallel-word requesters.
- Arbitrates round-robin and latches the granted word.
- Serializes the word MSB-first into the detector, one bit per clock, and counts pattern hits.
- Returns the hit count tagged with the requester ID.
- Sits between the parallel word sources and the bit-serial sequence-detection logic, and is the only driver of the detector input.

Parameters:
- W, 8, word width in bits (W >= PAT_LEN).
- PAT_LEN, 3, length of the detected pattern in bits (1..W).
- PATTERN, 3'b101, pattern to detect, MSB = oldest bit; width PAT_LEN.
- CW, $clog2(W+1), width of the match counter.

Ports:
- CLK, input, 1, rising-edge clock.
- RST, input, 1, reset; asynchronous, active-high.
- REQ, input, 2, request per requester; level, held until GNT.
- DATA0, input, W, requester 0 word; valid while REQ[0]=1.
- DATA1, input, W, requester 1 word; valid while REQ[1]=1.
- GNT, output, 2, one-hot one-cycle grant pulse; word has been captured.
- BUSY, output, 1, high in SHIFT and REPORT.
- X_OUT, output, 1, serial bit currently driven into the detector.
- Y_OUT, output, 1, detector hit for the current bit.
- DONE, output, 1, one-cycle pulse; result valid.
- DONE_ID, output, 1, requester index of the finished word.
- MATCH_CNT, output, CW, hits in the finished word; held until the next DONE.

Behaviour:
- Reset (async, any state), all registered:
  - State returns to IDLE.
  - GNT=0, BUSY=0, DONE=0, DONE_ID=0, MATCH_CNT=0, X_OUT=0, Y_OUT=0.
  - Detector history and bit count are cleared.
  - Round-robin pointer favours requester 0.
  - An in-flight word is discarded with no DONE and no GNT; requesters re-issue.
- FSM states are IDLE, SHIFT and REPORT.
- IDLE:
  - On a clock edge with REQ != 0, pick the winner and capture its DATA into the shift register.
  - Set GNT[winner]=1 for the next cycle only, load bit index = W-1, clear the detector and the hit counter, go to SHIFT.
  - Arbitration: if only one REQ bit is set, that requester wins. If both are set, the requester not granted last wins; after reset, requester 0 wins.
  - The pointer updates on every grant.
- SHIFT (exactly W cycles):
  - X_OUT = captured word[bit index]; index decrements W-1 down to 0.
  - The detector sees X_OUT in the same cycle.
  - Y_OUT is combinational from detector state + X_OUT and is registered into the hit counter at the clock edge.
  - After the cycle with index 0, go to REPORT.
- REPORT (1 cycle):
  - DONE=1, DONE_ID = winner, MATCH_CNT = final count (including the last bit's hit), X_OUT=0.
  - Next state is IDLE.
- Latency: REQ sampled at edge k → GNT high in cycle k+1 → first bit in cycle k+1 → DONE in cycle k+W+1.
- Throughput: one word per W+2 cycles (IDLE cycle is mandatory between words).
- Requests arriving during BUSY are ignored until IDLE; no queueing.
- A requester must drop REQ after its GNT, otherwise it is re-arbitrated.
- REQ dropped before GNT: nothing captured if it is low at the IDLE edge.
- Detector semantics:
  - Overlapping matches are counted.
  - History is cleared at each word start; no match spans two words.
  - A hit requires at least PAT_LEN bits received in the current word, so leading zero history cannot fake a match.
- Counter: width CW cannot overflow, since max hits = W-PAT_LEN+1; no saturation logic.

Decomposition:
- Package seq_arb_pkg:
  - State encoding (IDLE=2'd0, SHIFT=2'd1, REPORT=2'd2).
  - Default PATTERN/PAT_LEN constants.
  - Requester-ID constants.
- One sub-module, seq_detect_core, ports CLK, RST, CLR, EN, X, Y:
  - Holds a PAT_LEN-bit history shift register and a received-bit count.
  - Outputs Y = EN & (count >= PAT_LEN-1) & ({history, X} == PATTERN).
  - CLR is synchronous and has priority over EN.

Test Plan:
- Reset mid-SHIFT (assert RST at cycle 4 of a word) → immediately BUSY=0, GNT=0, DONE never pulses; next REQ[0] after release is serviced normally with a correct count.
- REQ=2'b01, DATA0=8'b10101010 → GNT=01 one cycle, X_OUT sequence 1,0,1,0,1,0,1,0, Y_OUT high on bits 3, 5 and 7 of the stream; DONE after 9 cycles, DONE_ID=0, MATCH_CNT=3.
- REQ=2'b10, DATA1=8'b00000101, then separately DATA1=8'b11111111 → MATCH_CNT=1 and MATCH_CNT=0 respectively; DONE_ID=1; no false hit from cleared history.
- Both REQ held from reset, DATA0=8'hAA, DATA1=8'h05 → grants alternate 0,1,0,1 with DONE_ID matching each grant and MATCH_CNT alternating 3,1; exactly one IDLE cycle between DONE and the next GNT.
- REQ[1] asserted during BUSY and dropped before IDLE → no grant to requester 1; next DONE_ID still reflects requester 0.
